// File: rtl/inst_queue_if.sv
// Handshake and decoded-payload bundle between the icache, inst_queue and dispatch.
interface inst_queue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [16:0] out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_opcode,
               out_rd, out_rs1, out_rs2, out_imm
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_opcode,
               out_rd, out_rs1, out_rs2, out_imm
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction fetch queue: decode on enqueue, circular storage, registered output stage.
// Optional IQ_BYPASS_EN lets an instruction skip storage when the queue is empty.
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SLACK  = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    inst_queue_if.slave       iq,
    output logic [ADDR_W:0]   count,
    output logic              overflow_err
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [16:0] opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } entry_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W+1:0] SLACK_W = (ADDR_W+2)'(SLACK);

    function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
        entry_t e;
        e.instr  = instr;
        e.pc     = pc;
        e.opcode = {instr[31:25], instr[14:12], instr[6:0]};
        e.rd     = instr[11:7];
        e.rs1    = instr[19:15];
        e.rs2    = instr[24:20];
        e.imm    = '0;
        case (instr[6:0])
            7'b0110111, 7'b0010111: e.imm = {instr[31:12], 12'b0};
            7'b1101111: e.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            7'b1100111, 7'b0000011: e.imm = {{20{instr[31]}}, instr[31:20]};
            7'b0010011: begin
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                    e.imm = {27'b0, instr[24:20]};
                else
                    e.imm = {{20{instr[31]}}, instr[31:20]};
            end
            7'b1100011: begin
                e.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                e.rd  = 5'd0;
            end
            7'b0100011: begin
                e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                e.rd  = 5'd0;
            end
            default: e.imm = '0;
        endcase
        return e;
    endfunction

    entry_t              mem_q [DEPTH];
    entry_t              out_q, out_d, in_dec;
    logic [ADDR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                out_valid_q, out_valid_d;
    logic                overflow_q, overflow_d;
    logic                full, empty, load_ok, bypass, do_enq, do_deq, live;

    assign in_dec  = decode(iq.in_instr, iq.in_pc);
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign load_ok = !out_valid_q || iq.out_ready;
    assign live    = rdy_in && !flush_in;

`ifdef IQ_BYPASS_EN
    assign bypass  = live && iq.in_valid && empty && load_ok;
`else
    assign bypass  = 1'b0;
`endif

    assign do_enq  = live && iq.in_valid && !full && !bypass;
    assign do_deq  = live && load_ok && !empty;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        out_d       = out_q;
        if (rdy_in && flush_in) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else if (rdy_in) begin
            if (iq.in_valid && full)
                overflow_d = 1'b1;
            if (do_deq) begin
                out_d       = mem_q[head_q];
                out_valid_d = 1'b1;
                head_d      = head_q + ADDR_W'(1);
            end else if (bypass) begin
                out_d       = in_dec;
                out_valid_d = 1'b1;
            end else if (iq.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (do_enq)
                tail_d = tail_q + ADDR_W'(1);
            if (do_enq && !do_deq)
                count_d = count_q + (ADDR_W+1)'(1);
            else if (!do_enq && do_deq)
                count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_q       <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            out_q       <= out_d;
        end
    end

    // Storage holds no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk_in) begin
        if (do_enq)
            mem_q[tail_q] <= in_dec;
    end

    assign iq.in_ready   = ({1'b0, count_q} + SLACK_W) <= DEPTH_W;
    assign iq.out_valid  = out_valid_q;
    assign iq.out_instr  = out_q.instr;
    assign iq.out_pc     = out_q.pc;
    assign iq.out_opcode = out_q.opcode;
    assign iq.out_rd     = out_q.rd;
    assign iq.out_rs1    = out_q.rs1;
    assign iq.out_rs2    = out_q.rs2;
    assign iq.out_imm    = out_q.imm;
    assign count         = count_q;
    assign overflow_err  = overflow_q;

endmodule
